// File: rtl/tile_map_ram.sv
// Tile-map memory: video read port with wrap-around scroll, CPU valid/ready port
// and a whole-map fill engine sharing one BRAM (one write port, one registered read port).
module tile_map_ram #(
  parameter int MAP_W_LOG2 = 6,
  parameter int MAP_H_LOG2 = 6,
  parameter int TILE_BITS  = 7,
  parameter int ATTR_BITS  = 3
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 cpu_valid,
  input  logic                                 cpu_we,
  input  logic [MAP_W_LOG2+MAP_H_LOG2-1:0]     cpu_addr,
  input  logic [31:0]                          cpu_wdata,
  output logic                                 cpu_ready,
  output logic [31:0]                          cpu_rdata,
  input  logic                                 frame_start,
  input  logic [MAP_W_LOG2-1:0]                scroll_x,
  input  logic [MAP_H_LOG2-1:0]                scroll_y,
  input  logic                                 vid_ren,
  input  logic [MAP_W_LOG2-1:0]                vid_x,
  input  logic [MAP_H_LOG2-1:0]                vid_y,
  output logic                                 vid_rvalid,
  output logic [TILE_BITS+ATTR_BITS-1:0]       vid_rdata,
  input  logic                                 fill_start,
  input  logic [TILE_BITS+ATTR_BITS-1:0]       fill_value,
  output logic                                 fill_busy,
  output logic                                 fill_done
);

  localparam int DW    = TILE_BITS + ATTR_BITS;
  localparam int AW    = MAP_W_LOG2 + MAP_H_LOG2;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    FILL_IDLE,
    FILL_BUSY
  } fill_state_t;

  fill_state_t          state, state_nxt;
  logic [AW-1:0]        fill_cnt, fill_cnt_nxt;
  logic [DW-1:0]        fill_val, fill_val_nxt;
  logic                 fill_done_nxt;

  logic [MAP_W_LOG2-1:0] sx;
  logic [MAP_H_LOG2-1:0] sy;
  logic [MAP_W_LOG2-1:0] vx_scrolled;
  logic [MAP_H_LOG2-1:0] vy_scrolled;
  logic                  v1_valid;
  logic [AW-1:0]         v1_addr;

  logic                  cpu_rd_q;
  logic                  cpu_wr_acc;
  logic                  cpu_rd_acc;

  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         ram_q;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_re;
  logic [AW-1:0]         mem_raddr;

  logic                  unused_wdata;

  assign unused_wdata = ^cpu_wdata[31:DW];

  // Fill engine: a running fill owns the write port and holds off CPU writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= FILL_IDLE;
      fill_cnt  <= '0;
      fill_val  <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      fill_val  <= fill_val_nxt;
      fill_done <= fill_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fill_cnt_nxt  = fill_cnt;
    fill_val_nxt  = fill_val;
    fill_done_nxt = 1'b0;
    case (state)
      FILL_IDLE: begin
        if (fill_start) begin
          state_nxt    = FILL_BUSY;
          fill_cnt_nxt = '0;
          fill_val_nxt = fill_value;
        end
      end
      FILL_BUSY: begin
        fill_cnt_nxt = fill_cnt + 1'b1;
        if (fill_cnt == {AW{1'b1}}) begin
          state_nxt     = FILL_IDLE;
          fill_done_nxt = 1'b1;
        end
      end
      default: state_nxt = FILL_IDLE;
    endcase
  end

  assign fill_busy = (state == FILL_BUSY);

  // A pending ready blocks re-acceptance, so one request never sees two ready pulses
  assign cpu_wr_acc = resetn & cpu_valid & cpu_we & ~cpu_ready &
                      (state == FILL_IDLE) & ~fill_start;
  assign cpu_rd_acc = cpu_valid & ~cpu_we & ~cpu_ready & ~v1_valid;

  assign vx_scrolled = vid_x + sx;
  assign vy_scrolled = vid_y + sy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sx         <= '0;
      sy         <= '0;
      v1_valid   <= 1'b0;
      v1_addr    <= '0;
      vid_rvalid <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rd_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        sx <= scroll_x;
        sy <= scroll_y;
      end
      v1_valid   <= vid_ren;
      if (vid_ren) begin
        v1_addr <= {vy_scrolled, vx_scrolled};
      end
      vid_rvalid <= v1_valid;
      cpu_ready  <= cpu_wr_acc | cpu_rd_acc;
      cpu_rd_q   <= cpu_rd_acc;
    end
  end

  assign mem_we    = fill_busy | cpu_wr_acc;
  assign mem_waddr = fill_busy ? fill_cnt : cpu_addr;
  assign mem_wdata = fill_busy ? fill_val : cpu_wdata[DW-1:0];
  assign mem_re    = v1_valid | cpu_rd_acc;
  assign mem_raddr = v1_valid ? v1_addr : cpu_addr;

  // Contents are never reset; a same-edge read sees the value before the write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      ram_q <= mem[mem_raddr];
    end
  end

  assign vid_rdata = vid_rvalid ? ram_q : '0;
  assign cpu_rdata = cpu_rd_q ? {{(32-DW){1'b0}}, ram_q} : 32'h0;

endmodule

// File: tb/tb_tile_map_ram.sv
// Directed self-checking bench for tile_map_ram: CPU access, scrolled video reads,
// arbitration stalls, fill engine, read-before-write and reset during fill.
module tb_tile_map_ram;

  localparam int AW = 12;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_valid;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          frame_start;
  logic [5:0]    scroll_x;
  logic [5:0]    scroll_y;
  logic          vid_ren;
  logic [5:0]    vid_x;
  logic [5:0]    vid_y;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;

  int            errors = 0;
  int            checks = 0;

  int            waited;
  logic [31:0]   rd;
  int            vcnt, vbad, ready_k, busy_cnt, done_cnt, done_j, ready_j, bad, done_seen;
  logic          cpu_done, exp_v;
  logic [DW-1:0] exp_d;

  tile_map_ram dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_valid  (cpu_valid),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .frame_start(frame_start),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .vid_ren    (vid_ren),
    .vid_x      (vid_x),
    .vid_y      (vid_y),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Upper data bits carry junk that the memory must discard
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int w);
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = {22'h3A5A5A, d};
    w = 0;
    do begin
      tick;
      w++;
    end while (!cpu_ready && w < 100);
    check_output("cpu_write_ready", 32'(cpu_ready), 32'h1);
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    tick;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [31:0] d, output int w);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = a;
    w = 0;
    do begin
      tick;
      w++;
    end while (!cpu_ready && w < 100);
    d = cpu_ready ? cpu_rdata : 32'hDEAD_DEAD;
    cpu_valid = 1'b0;
    tick;
  endtask

  initial begin
    resetn = 1'b0;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    frame_start = 1'b0; scroll_x = '0; scroll_y = '0;
    vid_ren = 1'b0; vid_x = '0; vid_y = '0;
    fill_start = 1'b0; fill_value = '0;
    tick;
    tick;
    check_output("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    check_output("rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
    check_output("rst_fill_busy", 32'(fill_busy), 32'h0);
    check_output("rst_fill_done", 32'(fill_done), 32'h0);
    check_output("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_output("rst_vid_rdata", 32'(vid_rdata), 32'h0);
    resetn = 1'b1;
    tick;

    // CPU write then read back, single-cycle latency each
    cpu_write(12'h041, 10'h2A5, waited);
    check_output("t1_write_latency", 32'(waited), 32'd1);
    check_output("t1_ready_pulse_drops", 32'(cpu_ready), 32'h0);
    cpu_read(12'h041, rd, waited);
    check_output("t1_read_latency", 32'(waited), 32'd1);
    check_output("t1_read_data", rd, 32'h0000_02A5);

    // Scroll load on frame_start; a same-edge request still sees the old scroll
    cpu_write(12'h001, 10'h011, waited);
    cpu_write(12'h040, 10'h140, waited);
    scroll_x = 6'd63; scroll_y = 6'd1; frame_start = 1'b1;
    vid_ren = 1'b1; vid_x = 6'd1; vid_y = 6'd0;
    tick;
    frame_start = 1'b0;
    check_output("t2_no_early_valid", 32'(vid_rvalid), 32'h0);
    tick;
    vid_ren = 1'b0;
    check_output("t2_old_scroll_valid", 32'(vid_rvalid), 32'h1);
    check_output("t2_old_scroll_data", 32'(vid_rdata), 32'h011);
    tick;
    check_output("t2_wrap_valid", 32'(vid_rvalid), 32'h1);
    check_output("t2_wrap_data", 32'(vid_rdata), 32'h140);
    tick;
    check_output("t2_valid_drops", 32'(vid_rvalid), 32'h0);
    scroll_x = 6'd0; scroll_y = 6'd0; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;

    // Ten back-to-back video reads stall a CPU read until the stream ends
    for (int i = 0; i < 10; i++) begin
      cpu_write(AW'(i), DW'(256 + i), waited);
    end
    vid_y = 6'd0; cpu_addr = 12'h041; cpu_we = 1'b0;
    cpu_done = 1'b0; vcnt = 0; vbad = 0; ready_k = -1; rd = '0;
    for (int k = 0; k <= 12; k++) begin
      vid_ren   = (k < 10);
      vid_x     = 6'(k);
      cpu_valid = (k >= 1) && !cpu_done;
      tick;
      exp_v = (k >= 1 && k <= 10);
      exp_d = DW'(256 + k - 1);
      if (vid_rvalid !== exp_v) vbad++;
      else if (exp_v && vid_rdata !== exp_d) vbad++;
      if (vid_rvalid) vcnt++;
      if (cpu_ready) begin
        ready_k  = k;
        rd       = cpu_rdata;
        cpu_done = 1'b1;
      end
    end
    cpu_valid = 1'b0;
    vid_ren = 1'b0;
    check_output("t3_vid_count", 32'(vcnt), 32'd10);
    check_output("t3_vid_stream_bad", 32'(vbad), 32'd0);
    check_output("t3_cpu_ready_cycle", 32'(ready_k), 32'd11);
    check_output("t3_cpu_rdata", rd, 32'h0000_02A5);
    tick;

    // Video read and CPU write hitting one cell on the same edge
    vid_ren = 1'b1; vid_x = 6'd5; vid_y = 6'd0;
    tick;
    vid_ren = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 32'h0000_03FF;
    tick;
    check_output("t5_cpu_ready", 32'(cpu_ready), 32'h1);
    check_output("t5_old_valid", 32'(vid_rvalid), 32'h1);
    check_output("t5_old_data", 32'(vid_rdata), 32'h105);
    cpu_valid = 1'b0; cpu_we = 1'b0;
    vid_ren = 1'b1;
    tick;
    vid_ren = 1'b0;
    tick;
    check_output("t5_new_data", 32'(vid_rdata), 32'h3FF);
    tick;

    // Whole-map fill with a CPU write and a second fill_start arriving mid-fill
    fill_value = 10'h155; fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    check_output("t4_busy_start", 32'(fill_busy), 32'h1);
    busy_cnt = 1; done_cnt = 0; done_j = -1; ready_j = -1;
    for (int j = 1; j <= 4200; j++) begin
      if (j == 50) begin
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 32'h0000_00AB;
      end
      if (j == 200) begin
        fill_start = 1'b1; fill_value = 10'h0F0;
      end else begin
        fill_start = 1'b0;
      end
      tick;
      if (fill_busy) busy_cnt++;
      if (fill_done) begin
        done_cnt++;
        done_j = j;
      end
      if (cpu_ready) begin
        ready_j = j;
        cpu_valid = 1'b0; cpu_we = 1'b0;
      end
    end
    check_output("t4_busy_cycles", 32'(busy_cnt), 32'd4096);
    check_output("t4_done_pulses", 32'(done_cnt), 32'd1);
    check_output("t4_done_cycle", 32'(done_j), 32'd4096);
    check_output("t4_cpu_write_after_fill", 32'(ready_j), 32'd4097);
    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      cpu_read(AW'(a), rd, waited);
      if (rd !== ((a == 32'h123) ? 32'h0AB : 32'h155)) bad++;
    end
    check_output("t4_bad_cells", 32'(bad), 32'd0);
    cpu_read(12'h123, rd, waited);
    check_output("t4_cpu_write_survives", rd, 32'h0AB);
    cpu_read(12'hFFF, rd, waited);
    check_output("t4_last_cell", rd, 32'h155);

    // Reset with the fill counter at 100 and a CPU write pending
    fill_value = 10'h2AA; fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 32'h0000_0077;
    repeat (100) tick;
    resetn = 1'b0;
    #1;
    check_output("t6_rst_busy", 32'(fill_busy), 32'h0);
    check_output("t6_rst_done", 32'(fill_done), 32'h0);
    check_output("t6_rst_cpu_ready", 32'(cpu_ready), 32'h0);
    check_output("t6_rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
    cpu_valid = 1'b0; cpu_we = 1'b0;
    done_seen = 0;
    repeat (3) begin
      tick;
      if (fill_done) done_seen++;
    end
    resetn = 1'b1;
    repeat (3) begin
      tick;
      if (fill_done || fill_busy) done_seen++;
    end
    check_output("t6_no_done_after_reset", 32'(done_seen), 32'd0);
    cpu_read(12'h063, rd, waited);
    check_output("t6_cell99_filled", rd, 32'h2AA);
    cpu_read(12'h064, rd, waited);
    check_output("t6_cell100_untouched", rd, 32'h155);
    cpu_read(12'h300, rd, waited);
    check_output("t6_dropped_write", rd, 32'h155);
    fill_value = 10'h000; fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    check_output("t6_refill_accepted", 32'(fill_busy), 32'h1);
    waited = 0;
    while (!fill_done && waited < 5000) begin
      tick;
      waited++;
    end
    check_output("t6_refill_done_cycle", 32'(waited), 32'd4096);
    tick;
    cpu_read(12'h300, rd, waited);
    check_output("t6_refill_data", rd, 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
